// File: rtl/alarm_ringer.sv
// Alarm ringer: compares the running time with the stored alert time once per
// second and drives a gated buzzer through IDLE / RING / SNOOZE with timeout.
module alarm_ringer #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       EN,
    input  logic       Tick1Hz,
    input  logic       Mode,
    input  logic [7:0] CurHour,
    input  logic [7:0] CurMin,
    input  logic [7:0] CurSec,
    input  logic       CurAPM,
    input  logic [7:0] AlertHour,
    input  logic [7:0] AlertMin,
    input  logic       AlertAPM,
    input  logic       Stop,
    input  logic       Snooze,
    output logic       Buzz,
    output logic       Ringing,
    output logic       Snoozing,
    output logic [1:0] SnoozeCnt,
    output logic [8:0] RemainSec
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    localparam logic [8:0] RING_LOAD   = 9'(RING_SECONDS);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECONDS);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t     state, state_n;
    logic [8:0] remain, remain_n;
    logic [1:0] cnt, cnt_n;
    logic       phase, phase_n;
    logic       stop_d, snooze_d;
    logic       stop_edge, snooze_edge, match, go_idle;

    assign stop_edge   = Stop & ~stop_d;
    assign snooze_edge = Snooze & ~snooze_d;
    assign match       = (CurHour == AlertHour) && (CurMin == AlertMin) &&
                         (CurSec == 8'h00) && (!Mode || (CurAPM == AlertAPM));

    always_comb begin
        state_n  = state;
        remain_n = remain;
        cnt_n    = cnt;
        phase_n  = phase;
        go_idle  = 1'b0;
        if (!EN) begin
            go_idle = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (Tick1Hz && match) begin
                        state_n  = RING;
                        remain_n = RING_LOAD;
                        cnt_n    = 2'd0;
                        phase_n  = 1'b1;
                    end
                end
                RING: begin
                    if (stop_edge) begin
                        go_idle = 1'b1;
                    end else if (snooze_edge) begin
                        // Out of snoozes: the snooze button acts as stop.
                        if (cnt < SNOOZE_MAX) begin
                            state_n  = SNOOZE;
                            remain_n = SNOOZE_LOAD;
                            cnt_n    = cnt + 2'd1;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end else if (Tick1Hz) begin
                        if (remain == 9'd1) begin
                            go_idle = 1'b1;
                        end else begin
                            remain_n = remain - 9'd1;
                            phase_n  = ~phase;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_edge) begin
                        go_idle = 1'b1;
                    end else if (Tick1Hz) begin
                        if (remain == 9'd1) begin
                            state_n  = RING;
                            remain_n = RING_LOAD;
                            phase_n  = 1'b1;
                        end else begin
                            remain_n = remain - 9'd1;
                        end
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end
        if (go_idle) begin
            state_n  = IDLE;
            remain_n = 9'd0;
            cnt_n    = 2'd0;
            phase_n  = 1'b0;
        end
    end

    // Outputs are registered from the next-state values so they change together.
    always_ff @(posedge Clk) begin
        if (RST) begin
            state    <= IDLE;
            remain   <= 9'd0;
            cnt      <= 2'd0;
            phase    <= 1'b0;
            stop_d   <= 1'b1;
            snooze_d <= 1'b1;
            Buzz     <= 1'b0;
            Ringing  <= 1'b0;
            Snoozing <= 1'b0;
        end else begin
            state    <= state_n;
            remain   <= remain_n;
            cnt      <= cnt_n;
            phase    <= phase_n;
            stop_d   <= Stop;
            snooze_d <= Snooze;
            Buzz     <= (state_n == RING) && phase_n;
            Ringing  <= (state_n == RING);
            Snoozing <= (state_n == SNOOZE);
        end
    end

    assign SnoozeCnt = cnt;
    assign RemainSec = remain;

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
Downstream consumer of the alarm-set stage. Compares the running clock time against the stored alert time (AlertHour/AlertMin/APM, BCD) once per second. On a match it drives a gated buzzer under a small FSM with timeout, snooze and stop. Sits between the alarm-set block, the main timekeeping counters and the buzzer/LED output pins.

Parameters:
RING_SECONDS, 60, seconds RING lasts before auto-return to IDLE (1..511)
SNOOZE_SECONDS, 300, seconds spent in SNOOZE before re-ringing (1..511)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3)

Ports:
Clk  input  1  system clock
RST  input  1  synchronous, active-high reset
EN  input  1  alarm armed; low forces IDLE
Tick1Hz  input  1  one-Clk-cycle pulse per second, aligned with the time counters
Mode  input  1  1 = 12-hour display (APM compared), 0 = 24-hour (APM ignored)
CurHour  input  8  current hour, BCD
CurMin  input  8  current minute, BCD
CurSec  input  8  current second, BCD
CurAPM  input  1  current AM/PM flag
AlertHour  input  8  alarm hour, BCD, from alarm-set stage
AlertMin  input  8  alarm minute, BCD
AlertAPM  input  1  alarm AM/PM flag
Stop  input  1  stop button, level, already debounced
Snooze  input  1  snooze button, level, already debounced
Buzz  output  1  buzzer drive
Ringing  output  1  high in RING
Snoozing  output  1  high in SNOOZE
SnoozeCnt  output  2  snoozes used in current event
RemainSec  output  9  seconds left in current RING/SNOOZE, 0 in IDLE

Behaviour:
- Reset: RST is synchronous and active-high, sampled on the Clk rising edge. State=IDLE. Buzz, Ringing, Snoozing, SnoozeCnt and RemainSec are all 0. Button-history registers are set to 1, so a button held through reset produces no edge.
- Edge detect: StopEdge = Stop & ~Stop_d, SnoozeEdge = Snooze & ~Snooze_d. History registers update every cycle.
- Match: (CurHour==AlertHour) & (CurMin==AlertMin) & (CurSec==8'h00) & (~Mode | (CurAPM==AlertAPM)). Only evaluated in a cycle where Tick1Hz=1.
- Cycle priority: RST, then EN low, then StopEdge, then SnoozeEdge, then Tick1Hz.
- All outputs are registered. Every state change is visible the cycle after the causing event.
- IDLE:
  - Tick1Hz & Match & EN -> RING. RemainSec=RING_SECONDS, SnoozeCnt=0, tone phase=1.
  - Button edges are ignored.
- RING:
  - StopEdge -> IDLE.
  - SnoozeEdge with SnoozeCnt<MAX_SNOOZE -> SNOOZE. RemainSec=SNOOZE_SECONDS, SnoozeCnt+1.
  - SnoozeEdge with SnoozeCnt==MAX_SNOOZE -> treated as Stop (IDLE).
  - Tick1Hz: if RemainSec==1 -> IDLE. Otherwise RemainSec-1 and the tone phase toggles.
  - A new Match while in RING is ignored; no reload.
- SNOOZE:
  - StopEdge -> IDLE.
  - SnoozeEdge is ignored.
  - Tick1Hz: if RemainSec==1 -> RING with RemainSec=RING_SECONDS and phase=1, SnoozeCnt held. Otherwise RemainSec-1.
- Any state with EN=0 -> IDLE next cycle. SnoozeCnt and RemainSec clear.
- Outputs by state:
  - Buzz = 1 only in RING with phase=1, giving a 1 s on / 1 s off pattern starting on.
  - Ringing = (state==RING).
  - Snoozing = (state==SNOOZE).
- On entry to IDLE: RemainSec=0 and SnoozeCnt=0.
- Counter arithmetic: RemainSec is a 9-bit unsigned binary count, not BCD. It never decrements below 1 inside RING or SNOOZE.
- Alert inputs changing mid-RING/SNOOZE has no effect until the next IDLE evaluation.
- RST mid-operation aborts to IDLE immediately (next edge). The buzzer is silent the cycle after.

Test Plan:
1. Trigger in 24-hour mode. Params RING_SECONDS=4, SNOOZE_SECONDS=3. Alert 07:30, Mode=0, EN=1. Drive Cur 07:30:00 with a Tick1Hz pulse. Required: Ringing=1 and Buzz=1 next cycle, RemainSec=4. Buzz toggles 1,0,1,0 on successive ticks. After the 4th tick Ringing=0 and RemainSec=0.
2. APM check in 12-hour mode. Mode=1, Alert 07:30 PM, Cur 07:30:00 AM with tick. Required: stays IDLE. Repeat with CurAPM=PM. Required: RING.
3. Snooze cycle. In RING, pulse Snooze. Required: Snoozing=1, SnoozeCnt=1, RemainSec=3, Buzz=0. After 3 ticks: Ringing=1, RemainSec=4, SnoozeCnt stays 1.
4. Snooze limit and priority. MAX_SNOOZE=1; after one snooze and re-ring, press Snooze. Required: IDLE. Separately, raise Stop and Snooze in the same cycle during RING. Required: IDLE, SnoozeCnt=0.
5. Stop during SNOOZE, EN drop, and held button. EN=0 mid-RING -> IDLE next cycle. Stop edge in SNOOZE -> IDLE. Stop held high through RST release -> no edge is detected.
6. No re-trigger. Stay at a matching HH:MM through seconds 01..59 after a Stop. Required: remains IDLE. Re-ring only occurs at the next HH:MM:00 match.
